// File: rtl/bitmap_slot_allocator.sv
// bitmap_slot_allocator
// Hands out the lowest-numbered free slot of a WORD_WIDTH-entry pool and takes
// slots back, tracking occupancy in a busy bitmap (1 = allocated).
// Optional feature macro: BITMAP_SLOT_ALLOCATOR_COUNT_EN adds a registered
// occupancy count output.
module bitmap_slot_allocator #(
   parameter int WORD_WIDTH  = 8,
   parameter int INDEX_WIDTH = 3
) (
   input  logic                   clock,
   input  logic                   reset_n,
   output logic                   alloc_valid,
   input  logic                   alloc_ready,
   output logic [INDEX_WIDTH-1:0] alloc_index,
   output logic [WORD_WIDTH-1:0]  alloc_onehot,
   input  logic                   release_valid,
   output logic                   release_ready,
   input  logic [INDEX_WIDTH-1:0] release_index,
   input  logic                   flush,
   output logic [WORD_WIDTH-1:0]  busy_map,
   output logic                   full,
   output logic                   empty,
`ifdef BITMAP_SLOT_ALLOCATOR_COUNT_EN
   output logic [INDEX_WIDTH:0]   occupancy,
`endif
   output logic                   release_error
);

   localparam logic [WORD_WIDTH-1:0]  ONE_W   = {{(WORD_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [INDEX_WIDTH:0]   ONE_CNT = {{INDEX_WIDTH{1'b0}}, 1'b1};

   // Binary position of the single set bit; zero when no bit is set.
   function automatic logic [INDEX_WIDTH-1:0] onehot_to_index(input logic [WORD_WIDTH-1:0] oh);
      logic [INDEX_WIDTH-1:0] idx;
      idx = {INDEX_WIDTH{1'b0}};
      for (int i = 0; i < WORD_WIDTH; i++) begin
         if (oh[i]) begin
            idx = idx | INDEX_WIDTH'(i);
         end else begin
            idx = idx;
         end
      end
      return idx;
   endfunction

   // Decodes a binary index to one-hot; indices beyond the pool decode to zero.
   function automatic logic [WORD_WIDTH-1:0] index_to_onehot(input logic [INDEX_WIDTH-1:0] idx);
      logic [WORD_WIDTH-1:0] oh;
      oh = {WORD_WIDTH{1'b0}};
      for (int i = 0; i < WORD_WIDTH; i++) begin
         oh[i] = (idx == INDEX_WIDTH'(i));
      end
      return oh;
   endfunction

   logic [WORD_WIDTH-1:0]  busy_q, busy_d;
   logic                   error_q, error_d;
   logic [WORD_WIDTH-1:0]  offer_onehot_s;
   logic [WORD_WIDTH-1:0]  release_onehot_s;
   logic                   full_s;
   logic                   alloc_fire_s;
   logic                   release_legal_s;
`ifdef BITMAP_SLOT_ALLOCATOR_COUNT_EN
   logic [INDEX_WIDTH:0]   count_q, count_d;
`endif

   // Offer and status are derived from the busy register only (no input-to-output paths).
   always_comb begin
      offer_onehot_s = ~busy_q & (busy_q + ONE_W);
      full_s         = &busy_q;
   end

   // Transfer qualification: alloc needs a live offer, release needs a busy slot in range.
   always_comb begin
      release_onehot_s = index_to_onehot(release_index);
      alloc_fire_s     = alloc_ready & ~full_s;
      release_legal_s  = release_valid & (|(release_onehot_s & busy_q));
   end

   // Next-state: alloc and release both act on the pre-edge bitmap, flush overrides both.
   always_comb begin
      busy_d  = busy_q;
      error_d = error_q | (release_valid & ~release_legal_s);
      if (flush) begin
         busy_d = {WORD_WIDTH{1'b0}};
      end else begin
         if (alloc_fire_s) begin
            busy_d = busy_d | offer_onehot_s;
         end else begin
            busy_d = busy_d;
         end
         if (release_legal_s) begin
            busy_d = busy_d & ~release_onehot_s;
         end else begin
            busy_d = busy_d;
         end
      end
   end

`ifdef BITMAP_SLOT_ALLOCATOR_COUNT_EN
   // Occupancy tracks the bitmap population: +1 per alloc, -1 per legal release.
   always_comb begin
      count_d = count_q;
      if (flush) begin
         count_d = {(INDEX_WIDTH+1){1'b0}};
      end else begin
         case ({alloc_fire_s, release_legal_s})
            2'b10:   count_d = count_q + ONE_CNT;
            2'b01:   count_d = count_q - ONE_CNT;
            default: count_d = count_q;
         endcase
      end
   end

   // Occupancy register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         count_q <= {(INDEX_WIDTH+1){1'b0}};
      end else begin
         count_q <= count_d;
      end
   end

   assign occupancy = count_q;
`endif

   // Busy bitmap and sticky release-error flag.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         busy_q  <= {WORD_WIDTH{1'b0}};
         error_q <= 1'b0;
      end else begin
         busy_q  <= busy_d;
         error_q <= error_d;
      end
   end

   assign alloc_onehot  = offer_onehot_s;
   assign alloc_index   = onehot_to_index(offer_onehot_s);
   assign alloc_valid   = ~full_s;
   assign release_ready = 1'b1;
   assign busy_map      = busy_q;
   assign full          = full_s;
   assign empty         = ~|busy_q;
   assign release_error = error_q;

endmodule

// File: tb/tb_bitmap_slot_allocator.sv
// Scoreboard bench for bitmap_slot_allocator (WORD_WIDTH = 8).
module tb_bitmap_slot_allocator;

   logic       clock;
   logic       reset_n;
   logic       alloc_valid;
   logic       alloc_ready;
   logic [2:0] alloc_index;
   logic [7:0] alloc_onehot;
   logic       release_valid;
   logic       release_ready;
   logic [2:0] release_index;
   logic       flush;
   logic [7:0] busy_map;
   logic       full;
   logic       empty;
   logic       release_error;
`ifdef BITMAP_SLOT_ALLOCATOR_COUNT_EN
   logic [3:0] occupancy;
`endif

   bitmap_slot_allocator #(.WORD_WIDTH(8), .INDEX_WIDTH(3)) dut (
      .clock(clock), .reset_n(reset_n),
      .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
      .alloc_index(alloc_index), .alloc_onehot(alloc_onehot),
      .release_valid(release_valid), .release_ready(release_ready),
      .release_index(release_index), .flush(flush),
      .busy_map(busy_map), .full(full), .empty(empty),
`ifdef BITMAP_SLOT_ALLOCATOR_COUNT_EN
      .occupancy(occupancy),
`endif
      .release_error(release_error)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   typedef struct {
      logic [7:0] busy;
      logic       err;
   } exp_t;

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;

   // reference model state: one flag per slot
   bit   mslot[8];
   bit   merr;

   task automatic check(input string name, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   function automatic int lowest_free(input logic [7:0] b);
      for (int i = 0; i < 8; i++) if (!b[i]) return i;
      return -1;
   endfunction

   function automatic int popcount(input logic [7:0] b);
      int n = 0;
      for (int i = 0; i < 8; i++) n += b[i];
      return n;
   endfunction

   function automatic logic [7:0] model_bits();
      logic [7:0] b;
      for (int i = 0; i < 8; i++) b[i] = mslot[i];
      return b;
   endfunction

   // Compare every DUT output against an expected bitmap/error pair.
   task automatic compare_state(input logic [7:0] b, input logic e);
      int lf;
      lf = lowest_free(b);
      check("busy_map", busy_map, b);
      check("release_error", release_error, e);
      check("full", full, (popcount(b) == 8) ? 1 : 0);
      check("empty", empty, (popcount(b) == 0) ? 1 : 0);
      check("alloc_valid", alloc_valid, (lf >= 0) ? 1 : 0);
      check("alloc_index", alloc_index, (lf >= 0) ? lf : 0);
      check("alloc_onehot", alloc_onehot, (lf >= 0) ? (1 << lf) : 0);
      check("release_ready", release_ready, 1);
`ifdef BITMAP_SLOT_ALLOCATOR_COUNT_EN
      check("occupancy", occupancy, popcount(b));
`endif
   endtask

   // Monitor: after each edge, pop the expectation for that edge and compare.
   initial begin
      exp_t e;
      forever begin
         @(posedge clock);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            compare_state(e.busy, e.err);
         end
      end
   end

   // Drive one cycle of stimulus and push the model's post-edge state.
   task automatic do_cycle(input logic rdy, input logic rv, input logic [2:0] ri, input logic fl);
      int   lf;
      bit   legal;
      exp_t e;
      @(negedge clock);
      alloc_ready   = rdy;
      release_valid = rv;
      release_index = ri;
      flush         = fl;
      lf    = lowest_free(model_bits());
      legal = rv && mslot[ri];
      if (rv && !legal) merr = 1'b1;
      if (fl) begin
         for (int i = 0; i < 8; i++) mslot[i] = 1'b0;
      end else begin
         if (legal) mslot[ri] = 1'b0;
         if (rdy && lf >= 0) mslot[lf] = 1'b1;
      end
      e.busy = model_bits();
      e.err  = merr;
      exp_q.push_back(e);
   endtask

   task automatic idle();
      @(negedge clock);
      alloc_ready = 1'b0; release_valid = 1'b0; release_index = 3'd0; flush = 1'b0;
   endtask

   task automatic settle();
      @(posedge clock);
      #2;
   endtask

   initial begin
      reset_n = 1'b0; alloc_ready = 1'b0; release_valid = 1'b0;
      release_index = 3'd0; flush = 1'b0;
      for (int i = 0; i < 8; i++) mslot[i] = 1'b0;
      merr = 1'b0;
      #12;
      compare_state(8'h00, 1'b0);
      check("reset_onehot", alloc_onehot, 8'h01);
      idle();
      reset_n = 1'b1;

      // fill the pool one slot per cycle
      for (int k = 0; k < 8; k++) do_cycle(1'b1, 1'b0, 3'd0, 1'b0);
      settle();
      check("fill_busy", busy_map, 8'hFF);
      check("fill_full", full, 1);
      check("fill_valid", alloc_valid, 0);
      check("fill_onehot", alloc_onehot, 8'h00);
      do_cycle(1'b1, 1'b0, 3'd0, 1'b0);   // alloc_ready while full: no effect
      settle();
      check("full_ready_noop", busy_map, 8'hFF);

      // shape 0xA7, then illegal and legal releases
      do_cycle(1'b0, 1'b1, 3'd3, 1'b0);
      do_cycle(1'b0, 1'b1, 3'd4, 1'b0);
      do_cycle(1'b0, 1'b1, 3'd6, 1'b0);
      settle();
      check("shape_a7", busy_map, 8'hA7);
      do_cycle(1'b0, 1'b1, 3'd3, 1'b0);
      settle();
      check("illegal_busy", busy_map, 8'hA7);
      check("illegal_err", release_error, 1);
      do_cycle(1'b0, 1'b1, 3'd2, 1'b0);
      settle();
      check("rel2_busy", busy_map, 8'hA3);
      check("rel2_index", alloc_index, 2);

      // 0x0F, then simultaneous alloc of 4 and release of 1
      do_cycle(1'b0, 1'b0, 3'd0, 1'b1);
      for (int k = 0; k < 4; k++) do_cycle(1'b1, 1'b0, 3'd0, 1'b0);
      settle();
      check("shape_0f", busy_map, 8'h0F);
      do_cycle(1'b1, 1'b1, 3'd1, 1'b0);
      settle();
      check("simul_busy", busy_map, 8'h1D);
      check("simul_index", alloc_index, 1);

      // fill, then flush with concurrent alloc and release
      for (int k = 0; k < 4; k++) do_cycle(1'b1, 1'b0, 3'd0, 1'b0);
      settle();
      check("refill", busy_map, 8'hFF);
      do_cycle(1'b1, 1'b1, 3'd5, 1'b1);
      settle();
      check("flush_busy", busy_map, 8'h00);
      check("flush_empty", empty, 1);
      check("flush_index", alloc_index, 0);
      check("flush_err_kept", release_error, 1);

      // asynchronous reset mid-burst, between edges
      for (int k = 0; k < 5; k++) do_cycle(1'b1, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 1'b0);
      @(posedge clock);
      #3;
      reset_n = 1'b0;
      #1;
      for (int i = 0; i < 8; i++) mslot[i] = 1'b0;
      merr = 1'b0;
      check("async_busy", busy_map, 8'h00);
      check("async_onehot", alloc_onehot, 8'h01);
      check("async_err", release_error, 0);
      idle();
      reset_n = 1'b1;

      // occupancy scenario: 5 allocs, 2 legal releases, 1 illegal release, flush
      for (int k = 0; k < 5; k++) do_cycle(1'b1, 1'b0, 3'd0, 1'b0);
      do_cycle(1'b0, 1'b1, 3'd1, 1'b0);
      do_cycle(1'b0, 1'b1, 3'd3, 1'b0);
      do_cycle(1'b0, 1'b1, 3'd3, 1'b0);
      settle();
      check("count_busy", busy_map, 8'h15);
`ifdef BITMAP_SLOT_ALLOCATOR_COUNT_EN
      check("count_three", occupancy, 3);
`endif
      do_cycle(1'b0, 1'b0, 3'd0, 1'b1);
      settle();
`ifdef BITMAP_SLOT_ALLOCATOR_COUNT_EN
      check("count_flush", occupancy, 0);
`endif

      // randomized traffic against the model
      for (int k = 0; k < 400; k++) begin
         logic fl;
         fl = ($urandom_range(0, 31) == 0);
         do_cycle(1'($urandom_range(0, 1)),
                  fl ? 1'b0 : 1'($urandom_range(0, 99) < 45),
                  3'($urandom_range(0, 7)), fl);
      end
      idle();
      settle();
      check("queue_drained", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
